alu_sequencer: RTL

Multi-cycle control sequencer for the `CPU_basic` datapath. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8-entry register file. It drives the combinational ALU's operand and select inputs, captures the ALU result and zero flag, and writes the result back. It also reports completion, branch outcome and illegal opcodes on a one-cycle done strobe.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/reg_file8.sv | 28 ++
 rtl/alu_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU selects, FSM states and instruction field positions shared by the sequencer.
package cpu_pkg;
    localparam logic [3:0] OP_PASS = 4'd0, OP_NOT = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_SLT = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8, OP_BEQ = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'h0, ALU_NOT = 4'h1, ALU_ADD = 4'h2, ALU_SUB = 4'h3;
    localparam logic [3:0] ALU_AND = 4'h4, ALU_OR = 4'h5, ALU_XOR = 4'h6, ALU_SLT = 4'h7;
    localparam int OP_MSB = 15, OP_LSB = 12, RD_MSB = 11, RD_LSB = 9;
    localparam int RS_MSB = 8, RS_LSB = 6, RT_MSB = 5, RT_LSB = 3, IMM_MSB = 5, IMM_LSB = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WRITE} state_t;
endpackage

// File: rtl/reg_file8.sv
// reg_file8: 8-entry register file, two read ports plus a debug port, r0 fixed at zero.
module reg_file8 #(
    parameter int word_size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           ra1_i,
    input  logic [2:0]           ra2_i,
    input  logic [2:0]           dbg_addr_i,
    input  logic                 we_i,
    input  logic [2:0]           wa_i,
    input  logic [word_size-1:0] wd_i,
    output logic [word_size-1:0] rd1_o,
    output logic [word_size-1:0] rd2_o,
    output logic [word_size-1:0] dbg_o
);
    logic [word_size-1:0] regs_q [8];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != 3'd0) begin
            regs_q[wa_i] <= wd_i;
        end
    end
    assign rd1_o = regs_q[ra1_i];
    assign rd2_o = regs_q[ra2_i];
    assign dbg_o = regs_q[dbg_addr_i];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state READ/EXEC/WRITE sequencer driving an external combinational ALU.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int word_size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic [word_size-1:0] alu_a,
    output logic [word_size-1:0] alu_b,
    output logic [3:0]           alu_sel,
    input  logic [word_size-1:0] alu_result,
    input  logic                 alu_zero,
    output logic                 done,
    output logic [word_size-1:0] result,
    output logic                 branch_taken,
    output logic                 illegal,
    input  logic [2:0]           dbg_addr,
    output logic [word_size-1:0] dbg_data
);
    state_t state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [word_size-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
    logic [word_size-1:0] rs_data, rt_data, imm_ext, wr_data;
    logic [3:0] sel_q, sel_d, op;
    logic zero_q, zero_d, done_q, done_d, bt_q, bt_d, ill_q, ill_d, wr_en, uses_alu;

    assign op       = instr_q[OP_MSB:OP_LSB];
    assign imm_ext  = {{(word_size-6){1'b0}}, instr_q[IMM_MSB:IMM_LSB]};
    assign uses_alu = op <= OP_SLT || op == OP_BEQ;
    assign wr_en    = state_q == ST_WRITE && op <= OP_LDI;
    assign wr_data  = op == OP_LDI ? imm_ext : res_q;

    reg_file8 #(.word_size(word_size)) u_rf (
        .clk(clk), .reset(reset),
        .ra1_i(instr_q[RS_MSB:RS_LSB]), .ra2_i(instr_q[RT_MSB:RT_LSB]), .dbg_addr_i(dbg_addr),
        .we_i(wr_en), .wa_i(instr_q[RD_MSB:RD_LSB]), .wd_i(wr_data),
        .rd1_o(rs_data), .rd2_o(rt_data), .dbg_o(dbg_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            bt_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            result_q <= result_d;
            bt_q     <= bt_d;
            ill_q    <= ill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        res_d    = res_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        result_d = result_q;
        bt_d     = bt_q;
        ill_d    = ill_q;
        case (state_q)
            ST_IDLE: begin
                state_d = instr_valid ? ST_READ : ST_IDLE;
                instr_d = instr_valid ? instr : instr_q;
            end
            ST_READ: begin
                // LDI and reserved opcodes leave the ALU inputs untouched
                a_d     = uses_alu ? rs_data : a_q;
                b_d     = uses_alu ? rt_data : b_q;
                sel_d   = uses_alu ? (op == OP_BEQ ? ALU_SUB : op) : sel_q;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = ST_WRITE;
            end
            default: begin
                done_d   = 1'b1;
                result_d = op > OP_BEQ ? '0 : wr_data;
                bt_d     = op == OP_BEQ && zero_q;
                ill_d    = op > OP_BEQ;
                state_d  = ST_IDLE;
            end
        endcase
    end

    assign instr_ready  = state_q == ST_IDLE;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_sel      = sel_q;
    assign done         = done_q;
    assign result       = result_q;
    assign branch_taken = bt_q;
    assign illegal      = ill_q;
endmodule
